// File: rtl/fetch_ir_unit_pkg.sv
// rtl/fetch_ir_unit_pkg.sv - shared fetch FSM encoding, NOP and RV32I opcode constants
package fetch_ir_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ir_unit.sv
// rtl/fetch_ir_unit.sv - instruction fetch with memory handshake, wait timeout and IR decode
module fetch_ir_unit
  import fetch_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      old_pc_q, old_pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_req_q, mem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = is_word_aligned(pc_q) ? ST_WAIT : ST_ERR;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath follows the state transition; the request address is captured from the
  // pre-write pc so a simultaneous pc_write only affects the following fetch.
  always_comb begin
    pc_d          = pc_write ? pc_next : pc_q;
    old_pc_d      = old_pc_q;
    ir_d          = ir_q;
    mem_addr_d    = mem_addr_q;
    mem_req_d     = (state_d == ST_WAIT);
    instr_valid_d = 1'b0;
    fetch_err_d   = (state_d == ST_ERR);
    cnt_d         = cnt_q;
    if (state_q == ST_IDLE && state_d == ST_WAIT) begin
      mem_addr_d = pc_q;
      cnt_d      = '0;
    end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == ST_WAIT && state_d == ST_IDLE) begin
      ir_d          = mem_rdata;
      old_pc_d      = mem_addr_q;
      instr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      ir_q          <= NOP_INSTR;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      ir_q          <= ir_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign old_pc      = old_pc_q;
  assign ir          = ir_q;
  assign mem_addr    = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign busy        = (state_q == ST_WAIT);

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign func3  = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign func7  = ir_q[31:25];

endmodule

// File: doc/fetch_ir_unit.md
FETCH_IR_UNIT -- requirements
Module: fetch_ir_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles waiting for mem_ready before error.
REQ-003 SHALL have ports: clk  input  1  clock; reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have fetch_req  input  1  controller request to fetch instruction at current pc.
REQ-005 SHALL have pc_write  input  1  load pc_next into pc; pc_next  input  32  next PC value.
REQ-006 SHALL have mem_req  output  1  memory read request; mem_addr  output  32  word address of request.
REQ-007 SHALL have mem_ready  input  1  read data valid; mem_rdata  input  32  instruction word.
REQ-008 SHALL have pc  output  32  current PC; old_pc  output  32  PC of instruction held in IR.
REQ-009 SHALL have ir  output  32  instruction register; opcode  output  7; func3  output  3; func7  output  7; rd, rs1, rs2  output  5 each.
REQ-010 SHALL have instr_valid  output  1  one-cycle pulse when IR updated; busy  output  1  fetch in progress; fetch_err  output  1  sticky error.

Function
REQ-011 FSM states SHALL be IDLE, WAIT, ERR; reset state IDLE.
REQ-012 In IDLE, fetch_req with pc[1:0]==0 SHALL register mem_addr<=pc, assert mem_req, go WAIT next cycle.
REQ-013 In IDLE, fetch_req with pc[1:0]!=0 SHALL go ERR, set fetch_err, issue no mem_req.
REQ-014 In WAIT, mem_req SHALL stay 1 and mem_addr stable until the cycle mem_ready==1 is sampled.
REQ-015 On mem_ready in WAIT: ir<=mem_rdata, old_pc<=mem_addr, instr_valid=1 next cycle for exactly one cycle, mem_req=0, return IDLE.
REQ-016 Fetch latency SHALL be 1 cycle request registration plus memory wait; with mem_ready held high, instr_valid appears 2 cycles after fetch_req.
REQ-017 Wait counter SHALL clear on entry to WAIT, increment each cycle without mem_ready; reaching TIMEOUT SHALL go ERR, drop mem_req, set fetch_err.
REQ-018 fetch_req while busy (WAIT) SHALL be ignored; no queueing.
REQ-019 pc_write SHALL update pc on any cycle in any state; in-flight fetch keeps registered mem_addr; old_pc unaffected.
REQ-020 Simultaneous pc_write and fetch_req in IDLE SHALL fetch old pc (pre-write value); new pc used by next fetch.
REQ-021 ERR SHALL be exited only by reset; fetch_err stays 1, fetch_req ignored, pc_write still honoured.
REQ-022 busy SHALL equal (state==WAIT).
REQ-023 Field outputs SHALL be combinational slices of ir: opcode=ir[6:0], rd=ir[11:7], func3=ir[14:12], rs1=ir[19:15], rs2=ir[24:20], func7=ir[31:25].
REQ-024 mem_ready outside WAIT SHALL be ignored.

Reset
REQ-025 reset==0 at posedge clk SHALL set: pc=RESET_PC, old_pc=RESET_PC, ir=32'h0000_0013 (NOP), mem_req=0, mem_addr=0, instr_valid=0, fetch_err=0, counter=0, state IDLE.
REQ-026 Reset mid-fetch SHALL abandon request; mem_ready arriving after reset SHALL not update ir.
REQ-027 reset SHALL take priority over pc_write and fetch_req in same cycle.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, NOP constant 32'h0000_0013, and RV32I opcode constants shared with the controller.
REQ-029 Single module, no sub-modules; wait counter width $clog2(TIMEOUT+1).

Verification
REQ-030 Reset then fetch_req, mem_ready high, mem_rdata=32'h00500093 -> instr_valid 2 cycles later, ir=32'h00500093, opcode=7'b0010011, rd=1, old_pc=0.
REQ-031 fetch_req at pc=32'h10, mem_ready after 5 wait cycles -> mem_req high 5 cycles, mem_addr=32'h10 stable, single instr_valid pulse.
REQ-032 pc_write with pc_next=32'h20 during WAIT at pc=32'h10 -> ir from address 32'h10, old_pc=32'h10, pc=32'h20.
REQ-033 pc_next=32'h22, pc_write then fetch_req -> fetch_err=1, mem_req never asserted, further fetch_req ignored until reset.
REQ-034 TIMEOUT=16, mem_ready never asserted -> ERR after 16 wait cycles, mem_req drops, fetch_err=1; reset clears all outputs to REQ-025 values.
REQ-035 Reset asserted during WAIT, mem_ready next cycle -> ir stays 32'h00000013, instr_valid stays 0.
